// File: rtl/fft_stage_sequencer.sv
// -----------------------------------------------------------------------------
// fft_stage_sequencer
//
// Walks the radix-2 butterfly core through all FFT_N stages of one in-place
// FFT frame. For each stage it issues one butterfly pair index per cycle
// (tagging the first and last pair), waits for the core's write-back stream to
// drain, then flips the ping-pong RAM bank and advances to the next stage.
//
// Ports
//   clk        clock
//   reset      synchronous, active-high reset
//   start      1-cycle pulse, begins a frame (accepted from idle only)
//   hold       stalls pair issue (RAM port / twiddle not ready)
//   busy       high from accepted start until done
//   done       1-cycle pulse at end of frame (normal or drain timeout)
//   err        sticky: drain timeout or write-back count mismatch
//   fft_stage  current stage index for core and twiddle ROM
//   bf_iact    pair valid to core
//   bf_ictrl   [0]=first pair of stage, [1]=last pair of stage
//   rd_addr    pair index of this issue
//   rd_bank    ping-pong bank read this stage (write bank is ~rd_bank)
//   bf_oact    core write-back valid
//   bf_octrl   write-back tags, same encoding as bf_ictrl
// -----------------------------------------------------------------------------
module fft_stage_sequencer #(
    parameter int FFT_N          = 10,
    parameter int STAGE_COUNT_BW = 4,
    parameter int DRAIN_TIMEOUT  = 64
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      hold,
    output logic                      busy,
    output logic                      done,
    output logic                      err,
    output logic [STAGE_COUNT_BW-1:0] fft_stage,
    output logic                      bf_iact,
    output logic [1:0]                bf_ictrl,
    output logic [FFT_N-2:0]          rd_addr,
    output logic                      rd_bank,
    input  logic                      bf_oact,
    input  logic [1:0]                bf_octrl
);

    localparam int PAIR_BW = FFT_N - 1;
    localparam int RET_BW  = FFT_N;
    localparam int TO_BW   = $clog2(DRAIN_TIMEOUT + 1);

    localparam logic [PAIR_BW-1:0]        LAST_PAIR  = '1;
    localparam logic [RET_BW-1:0]         RET_LAST   = RET_BW'((1 << (FFT_N - 1)) - 1);
    localparam logic [TO_BW-1:0]          TO_LAST    = TO_BW'(DRAIN_TIMEOUT - 1);
    localparam logic [STAGE_COUNT_BW-1:0] LAST_STAGE = STAGE_COUNT_BW'(FFT_N - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_NEXT
    } state_t;

    state_t                    state_reg,     state_next;
    logic [PAIR_BW-1:0]        pair_cnt_reg,  pair_cnt_next;
    logic [RET_BW-1:0]         ret_cnt_reg,   ret_cnt_next;
    logic [TO_BW-1:0]          drain_cnt_reg, drain_cnt_next;
    logic                      busy_reg,      busy_next;
    logic                      done_reg,      done_next;
    logic                      err_reg,       err_next;
    logic [STAGE_COUNT_BW-1:0] stage_reg,     stage_next;
    logic                      iact_reg,      iact_next;
    logic [1:0]                ictrl_reg,     ictrl_next;
    logic [PAIR_BW-1:0]        rd_addr_reg,   rd_addr_next;
    logic                      rd_bank_reg,   rd_bank_next;

    // The first-of-stage return tag carries no information for draining;
    // only the last-pair tag ends a stage.
    logic unused_octrl_first;
    assign unused_octrl_first = bf_octrl[0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= S_IDLE;
            pair_cnt_reg  <= '0;
            ret_cnt_reg   <= '0;
            drain_cnt_reg <= '0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            err_reg       <= 1'b0;
            stage_reg     <= '0;
            iact_reg      <= 1'b0;
            ictrl_reg     <= 2'b00;
            rd_addr_reg   <= '0;
            rd_bank_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            pair_cnt_reg  <= pair_cnt_next;
            ret_cnt_reg   <= ret_cnt_next;
            drain_cnt_reg <= drain_cnt_next;
            busy_reg      <= busy_next;
            done_reg      <= done_next;
            err_reg       <= err_next;
            stage_reg     <= stage_next;
            iact_reg      <= iact_next;
            ictrl_reg     <= ictrl_next;
            rd_addr_reg   <= rd_addr_next;
            rd_bank_reg   <= rd_bank_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        pair_cnt_next  = pair_cnt_reg;
        ret_cnt_next   = ret_cnt_reg;
        drain_cnt_next = drain_cnt_reg;
        busy_next      = busy_reg;
        done_next      = 1'b0;
        err_next       = err_reg;
        stage_next     = stage_reg;
        iact_next      = 1'b0;
        ictrl_next     = 2'b00;
        rd_addr_next   = rd_addr_reg;
        rd_bank_next   = rd_bank_reg;

        // Write-backs may start arriving before the last pair is issued, so
        // they are counted in both ISSUE and DRAIN.
        if ((state_reg == S_ISSUE || state_reg == S_DRAIN) && bf_oact) begin
            ret_cnt_next = ret_cnt_reg + RET_BW'(1);
        end

        case (state_reg)
            S_IDLE: begin
                // done_reg is high during the first idle cycle; a start in
                // that cycle belongs to the frame just finished and is dropped.
                if (start && !done_reg) begin
                    state_next     = S_ISSUE;
                    stage_next     = '0;
                    rd_bank_next   = 1'b0;
                    pair_cnt_next  = '0;
                    ret_cnt_next   = '0;
                    drain_cnt_next = '0;
                    err_next       = 1'b0;
                    busy_next      = 1'b1;
                end
            end

            S_ISSUE: begin
                if (!hold) begin
                    iact_next     = 1'b1;
                    rd_addr_next  = pair_cnt_reg;
                    ictrl_next    = {pair_cnt_reg == LAST_PAIR, pair_cnt_reg == '0};
                    pair_cnt_next = pair_cnt_reg + PAIR_BW'(1);
                    if (pair_cnt_reg == LAST_PAIR) begin
                        state_next     = S_DRAIN;
                        drain_cnt_next = '0;
                    end
                end
            end

            S_DRAIN: begin
                drain_cnt_next = drain_cnt_reg + TO_BW'(1);
                if (bf_oact && bf_octrl[1]) begin
                    // Last-tagged return: the stage is over either way, but a
                    // short or long count means data was lost or duplicated.
                    if (ret_cnt_reg != RET_LAST) begin
                        err_next = 1'b1;
                    end
                    state_next = S_NEXT;
                end else if (drain_cnt_reg == TO_LAST) begin
                    err_next   = 1'b1;
                    state_next = S_IDLE;
                    done_next  = 1'b1;
                    busy_next  = 1'b0;
                end
            end

            S_NEXT: begin
                rd_bank_next  = ~rd_bank_reg;
                pair_cnt_next = '0;
                ret_cnt_next  = '0;
                if (stage_reg == LAST_STAGE) begin
                    state_next = S_IDLE;
                    done_next  = 1'b1;
                    busy_next  = 1'b0;
                end else begin
                    stage_next = stage_reg + STAGE_COUNT_BW'(1);
                    state_next = S_ISSUE;
                end
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign busy      = busy_reg;
    assign done      = done_reg;
    assign err       = err_reg;
    assign fft_stage = stage_reg;
    assign bf_iact   = iact_reg;
    assign bf_ictrl  = ictrl_reg;
    assign rd_addr   = rd_addr_reg;
    assign rd_bank   = rd_bank_reg;

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fft_stage_sequencer
//
// Bench for fft_stage_sequencer with FFT_N=4 (4 stages x 8 pairs) driving a
// loopback core model of latency 6. Every expected issue is pushed to a
// scoreboard queue when a frame is started and popped when the DUT issues.
// -----------------------------------------------------------------------------
module tb_fft_stage_sequencer;

    localparam int N     = 4;
    localparam int SBW   = 4;
    localparam int TO    = 64;
    localparam int LAT   = 6;
    localparam int PAIRS = 8;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           start = 1'b0;
    logic           hold = 1'b0;
    logic           busy;
    logic           done;
    logic           err;
    logic [SBW-1:0] fft_stage;
    logic           bf_iact;
    logic [1:0]     bf_ictrl;
    logic [N-2:0]   rd_addr;
    logic           rd_bank;
    logic           bf_oact = 1'b0;
    logic [1:0]     bf_octrl = 2'b00;

    fft_stage_sequencer #(
        .FFT_N          (N),
        .STAGE_COUNT_BW (SBW),
        .DRAIN_TIMEOUT  (TO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .hold      (hold),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .fft_stage (fft_stage),
        .bf_iact   (bf_iact),
        .bf_ictrl  (bf_ictrl),
        .rd_addr   (rd_addr),
        .rd_bank   (rd_bank),
        .bf_oact   (bf_oact),
        .bf_octrl  (bf_octrl)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Scoreboard entry: {stage, bank, ictrl, addr}
    logic [9:0] exp_q[$];

    task automatic push_frame(input int nstages);
        logic [9:0] e;
        for (int s = 0; s < nstages; s++) begin
            for (int a = 0; a < PAIRS; a++) begin
                e = {4'(s), 1'(s), (a == PAIRS - 1), (a == 0), 3'(a)};
                exp_q.push_back(e);
            end
        end
    endtask

    // Loopback core model: echoes issues after LAT cycles, with fault knobs.
    bit   drop_en       = 1'b0;   // lose stage 2, pair 3
    bit   suppress_last = 1'b0;   // never return the last-tagged pair
    logic       pipe_act [LAT];
    logic [1:0] pipe_ctl [LAT];

    always @(negedge clk) begin : core_model
        logic a;
        if (reset) begin
            for (int i = 0; i < LAT; i++) begin
                pipe_act[i] = 1'b0;
                pipe_ctl[i] = 2'b00;
            end
        end else begin
            for (int i = LAT - 1; i > 0; i--) begin
                pipe_act[i] = pipe_act[i-1];
                pipe_ctl[i] = pipe_ctl[i-1];
            end
            a = bf_iact;
            if (drop_en && fft_stage == 4'd2 && rd_addr == 3'd3) a = 1'b0;
            if (suppress_last && bf_ictrl[1]) a = 1'b0;
            pipe_act[0] = a;
            pipe_ctl[0] = bf_ictrl;
        end
        bf_oact  = pipe_act[LAT-1];
        bf_octrl = pipe_act[LAT-1] ? pipe_ctl[LAT-1] : 2'b00;
    end

    // Monitor
    int   cyc = 0;
    int   done_cnt = 0;
    int   done_cyc = 0;
    int   last_tag_cyc = 0;
    logic hold_s = 1'b0;

    always @(posedge clk) hold_s <= hold;

    always @(negedge clk) begin : monitor
        logic [9:0] got;
        logic [9:0] exp;
        cyc++;
        if (!reset) begin
            if (hold_s) check_eq("iact_under_hold", 32'(bf_iact), 32'd0);
            if (bf_iact) begin
                got = {fft_stage, rd_bank, bf_ictrl, rd_addr};
                if (bf_ictrl[1]) last_tag_cyc = cyc;
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_issue", 32'(got), 32'h3ff);
                end else begin
                    exp = exp_q.pop_front();
                    $display("issue stage=%0d bank=%0d addr=%0d ictrl=%b", fft_stage, rd_bank, rd_addr, bf_ictrl);
                    check_eq("issue", 32'(got), 32'(exp));
                end
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                $display("done err=%0d bank=%0d", err, rd_bank);
                check_eq("busy_at_done", 32'(busy), 32'd0);
            end
        end
    end

    task automatic check_reset_values(input string pfx);
        check_eq({pfx, "_busy"},  32'(busy),      32'd0);
        check_eq({pfx, "_done"},  32'(done),      32'd0);
        check_eq({pfx, "_err"},   32'(err),       32'd0);
        check_eq({pfx, "_stage"}, 32'(fft_stage), 32'd0);
        check_eq({pfx, "_iact"},  32'(bf_iact),   32'd0);
        check_eq({pfx, "_ictrl"}, 32'(bf_ictrl),  32'd0);
        check_eq({pfx, "_addr"},  32'(rd_addr),   32'd0);
        check_eq({pfx, "_bank"},  32'(rd_bank),   32'd0);
    endtask

    task automatic pulse_start(input int nstages, input bit accept);
        if (accept) push_frame(nstages);
        @(negedge clk); #1;
        start = 1'b1;
        @(negedge clk); #1;
        start = 1'b0;
        if (accept) begin
            check_eq("busy_after_start", 32'(busy), 32'd1);
            check_eq("err_cleared_by_start", 32'(err), 32'd0);
        end
    endtask

    task automatic wait_done(input int budget, input bit toggle);
        int  d0;
        bit  ok;
        d0 = done_cnt;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk); #1;
            if (toggle) hold = ~hold;
            if (done_cnt != d0) begin
                ok = 1'b1;
                break;
            end
        end
        hold = 1'b0;
        check_eq("done_within_budget", 32'(ok), 32'd1);
    endtask

    task automatic frame_end_checks(input string pfx, input int d0, input bit exp_err, input bit exp_bank);
        repeat (5) @(negedge clk);
        #1;
        check_eq({pfx, "_single_done"}, 32'(done_cnt - d0), 32'd1);
        check_eq({pfx, "_err"},         32'(err),           32'(exp_err));
        check_eq({pfx, "_busy_low"},    32'(busy),          32'd0);
        check_eq({pfx, "_bank"},        32'(rd_bank),       32'(exp_bank));
        check_eq({pfx, "_sb_empty"},    32'(exp_q.size()),  32'd0);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin : stimulus
        int  d0;
        bit  found;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check_reset_values("reset");
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // 1: plain frame
        d0 = done_cnt;
        pulse_start(N, 1'b1);
        wait_done(400, 1'b0);
        frame_end_checks("t1", d0, 1'b0, 1'b0);

        // 2: hold on alternate cycles
        d0 = done_cnt;
        pulse_start(N, 1'b1);
        wait_done(600, 1'b1);
        frame_end_checks("t2", d0, 1'b0, 1'b0);

        // 3: one write-back lost in stage 2
        drop_en = 1'b1;
        d0 = done_cnt;
        pulse_start(N, 1'b1);
        wait_done(400, 1'b0);
        drop_en = 1'b0;
        frame_end_checks("t3", d0, 1'b1, 1'b0);

        // 4: last-tagged write-back never returns -> drain timeout in stage 0
        suppress_last = 1'b1;
        d0 = done_cnt;
        pulse_start(1, 1'b1);
        wait_done(300, 1'b0);
        check_eq("t4_timeout_cycles", 32'(done_cyc - last_tag_cyc), 32'(TO));
        frame_end_checks("t4", d0, 1'b1, 1'b0);
        suppress_last = 1'b0;
        repeat (10) @(negedge clk);

        // 5: reset at stage 1, pair 3
        d0 = done_cnt;
        pulse_start(N, 1'b1);
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk); #1;
            if (bf_iact && fft_stage == 4'd1 && rd_addr == 3'd3) begin
                found = 1'b1;
                break;
            end
        end
        check_eq("t5_reached_s1p3", 32'(found), 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        check_reset_values("t5_reset");
        reset = 1'b0;
        exp_q.delete();
        repeat (12) @(negedge clk);
        #1;
        check_eq("t5_no_done", 32'(done_cnt - d0), 32'd0);
        check_eq("t5_idle", 32'(busy), 32'd0);
        d0 = done_cnt;
        pulse_start(N, 1'b1);
        wait_done(400, 1'b0);
        frame_end_checks("t5_clean", d0, 1'b0, 1'b0);

        // 6: start while busy and in the done cycle are ignored
        d0 = done_cnt;
        pulse_start(N, 1'b1);
        repeat (20) @(negedge clk);
        pulse_start(N, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk); #1;
            if (done) begin
                found = 1'b1;
                start = 1'b1;
                @(negedge clk); #1;
                start = 1'b0;
                break;
            end
        end
        check_eq("t6_done_seen", 32'(found), 32'd1);
        repeat (30) @(negedge clk);
        #1;
        check_eq("t6_start_in_done_ignored", 32'(busy), 32'd0);
        check_eq("t6_single_done", 32'(done_cnt - d0), 32'd1);
        check_eq("t6_sb_empty", 32'(exp_q.size()), 32'd0);
        check_eq("t6_err", 32'(err), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
